// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// FIFO controller that keeps its storage in an external simple dual-port RAM.
// It owns the read/write pointers, the occupancy count, the full/empty flags
// and sticky overflow/underflow flags. It drives the RAM write port directly
// from accepted pushes and the RAM read port from accepted pops. The RAM
// returns read data one cycle after the read request, so rd_valid is a
// one-cycle-delayed copy of the accepted pop.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid, in_data          push request and data
//   in_ready                   push can be accepted (!full)
//   rd_en                      pop request
//   rd_data, rd_valid          popped data, valid for one cycle after a pop
//   full, empty, count         occupancy status (count ranges 0..DEPTH)
//   ovf_err, udf_err           sticky push-when-full / pop-when-empty flags
//   ram_port_en_0, ram_wr_en   RAM write-port enables
//   ram_addr_0, ram_data_in    RAM write address and data
//   ram_port_en_1, ram_addr_1  RAM read-port enable and address
//   ram_data_out_1             RAM read data (registered inside the RAM)
module ram_fifo_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf_err,
    output logic          udf_err,
    output logic          ram_port_en_0,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr_0,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_port_en_1,
    output logic [AW-1:0] ram_addr_1,
    input  logic [DW-1:0] ram_data_out_1
);

    localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   COUNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          rd_valid_r;
    logic          ovf_r;
    logic          udf_r;

    logic          full_s;
    logic          empty_s;
    logic          push_acc_s;
    logic          pop_acc_s;

    // Occupancy flags and request acceptance. Reset forces the FIFO to look
    // empty and not full, and blocks every RAM access, even before the
    // registers have actually been cleared by the reset edge.
    always_comb begin
        full_s     = 1'b0;
        empty_s    = 1'b1;
        push_acc_s = 1'b0;
        pop_acc_s  = 1'b0;
        if (rst) begin
            full_s     = 1'b0;
            empty_s    = 1'b1;
            push_acc_s = 1'b0;
            pop_acc_s  = 1'b0;
        end else begin
            full_s     = (count_r == COUNT_FULL);
            empty_s    = (count_r == COUNT_ZERO);
            // A pop while empty or a push while full is refused, which also
            // resolves simultaneous push/pop at those two boundaries.
            push_acc_s = in_valid & ~full_s;
            pop_acc_s  = rd_en & ~empty_s;
        end
    end

    // Pointers, occupancy, read-valid pipeline stage and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= COUNT_ZERO;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
            udf_r      <= 1'b0;
        end else begin
            // Pointers are AW bits and DEPTH is 2**AW, so they wrap naturally.
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
            // The RAM answers one cycle after the read request.
            rd_valid_r <= pop_acc_s;
            if (in_valid & full_s) begin
                ovf_r <= 1'b1;
            end
            if (rd_en & empty_s) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign in_ready      = ~full_s;
    assign full          = full_s;
    assign empty         = empty_s;
    assign count         = count_r;
    assign ovf_err       = ovf_r;
    assign udf_err       = udf_r;
    assign rd_valid      = rd_valid_r;
    assign rd_data       = ram_data_out_1;

    assign ram_port_en_0 = push_acc_s;
    assign ram_wr_en     = push_acc_s;
    assign ram_addr_0    = wr_ptr_r;
    assign ram_data_in   = in_data;
    assign ram_port_en_1 = pop_acc_s;
    assign ram_addr_1    = rd_ptr_r;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM, a reference
// model of the controller state and a data scoreboard.
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = 8'h00;
    logic          in_ready;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf_err;
    logic          udf_err;
    logic          ram_port_en_0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr_0;
    logic [DW-1:0] ram_data_in;
    logic          ram_port_en_1;
    logic [AW-1:0] ram_addr_1;
    logic [DW-1:0] ram_data_out_1;

    ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .ovf_err        (ovf_err),
        .udf_err        (udf_err),
        .ram_port_en_0  (ram_port_en_0),
        .ram_wr_en      (ram_wr_en),
        .ram_addr_0     (ram_addr_0),
        .ram_data_in    (ram_data_in),
        .ram_port_en_1  (ram_port_en_1),
        .ram_addr_1     (ram_addr_1),
        .ram_data_out_1 (ram_data_out_1)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q = 8'h00;
    always @(posedge clk) begin
        if (ram_port_en_0 && ram_wr_en) mem[ram_addr_0] <= ram_data_in;
        if (ram_port_en_1) ram_q <= mem[ram_addr_1];
    end
    assign ram_data_out_1 = ram_q;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Reference model state
    int m_count = 0;
    int m_wr    = 0;
    int m_rd    = 0;
    bit m_ovf   = 1'b0;
    bit m_udf   = 1'b0;
    bit m_rv    = 1'b0;
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] rd_q [$];

    typedef struct {
        bit          r;
        bit          iv;
        logic [7:0]  d;
        bit          re;
        int          cnt;
        bit          f;
        bit          e;
        bit          ovf;
        bit          udf;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, then
    // advance the model across the edge.
    task automatic step(input bit r, input bit iv, input logic [7:0] d, input bit re);
        bit mf, me, pa, qa;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; rd_en = re;
        #1;
        mf = !r && (m_count == DEPTH);
        me = r || (m_count == 0);
        pa = iv && !mf && !r;
        qa = re && !me && !r;
        chk("full",     32'(full),          32'(mf));
        chk("empty",    32'(empty),         32'(me));
        chk("in_ready", 32'(in_ready),      32'(!mf));
        chk("port_en0", 32'(ram_port_en_0), 32'(pa));
        chk("wr_en",    32'(ram_wr_en),     32'(pa));
        chk("port_en1", 32'(ram_port_en_1), 32'(qa));
        if (pa) begin
            chk("addr0",   32'(ram_addr_0),  32'(m_wr));
            chk("data_in", 32'(ram_data_in), 32'(d));
        end
        if (qa) chk("addr1", 32'(ram_addr_1), 32'(m_rd));
        if (chk_on) begin
            chk("count",    32'(count),    32'(m_count));
            chk("rd_valid", 32'(rd_valid), 32'(m_rv));
            chk("ovf_err",  32'(ovf_err),  32'(m_ovf));
            chk("udf_err",  32'(udf_err),  32'(m_udf));
            if (m_rv && rd_valid === 1'b1) begin
                chk("rd_q_nonempty", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            end
        end
        @(posedge clk);
        if (r) begin
            m_count = 0; m_wr = 0; m_rd = 0;
            m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
            sb_q.delete(); rd_q.delete();
            chk_on = 1'b1;
        end else begin
            if (iv && mf) m_ovf = 1'b1;
            if (re && me) m_udf = 1'b1;
            if (qa) begin
                rd_q.push_back(sb_q.pop_front());
                m_rd = (m_rd + 1) % DEPTH;
            end
            if (pa) begin
                sb_q.push_back(d);
                m_wr = (m_wr + 1) % DEPTH;
            end
            m_rv = qa;
            m_count = m_count + (pa ? 1 : 0) - (qa ? 1 : 0);
        end
    endtask

    initial begin
        //            r     iv    d      re    cnt f     e     ovf   udf
        tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'hA2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'hA3, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 8'hB1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Table-driven basics: reset, push/pop, pop on empty, push+pop on empty
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].r, tbl[k].iv, tbl[k].d, tbl[k].re);
            #1;
            chk("tbl_count", 32'(count),   32'(tbl[k].cnt));
            chk("tbl_full",  32'(full),    32'(tbl[k].f));
            chk("tbl_empty", 32'(empty),   32'(tbl[k].e));
            chk("tbl_ovf",   32'(ovf_err), 32'(tbl[k].ovf));
            chk("tbl_udf",   32'(udf_err), 32'(tbl[k].udf));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset for two cycles
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        #1;
        chk("rst_count",  32'(count),    32'd0);
        chk("rst_ready",  32'(in_ready), 32'd1);
        chk("rst_errors", 32'({ovf_err, udf_err}), 32'd0);

        // Fill 1..16, then a refused 17th push
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        #1;
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full),  32'd1);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        #1;
        chk("fill_ovf",   32'(ovf_err), 32'd1);
        chk("fill_count2", 32'(count),  32'd16);

        // Drain 16, then a refused pop
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        #1;
        chk("drain_udf", 32'(udf_err), 32'd1);

        // Wrap: push 10, pop 10, push 0x20..0x29 across the 15->0 boundary
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
            if (i == 5) begin
                #1;
                chk("wrap_addr0", 32'(ram_addr_0), 32'd0);
            end
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous push/pop at count 5
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b1);
        #1;
        chk("simul_count", 32'(count), 32'd5);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-fill, with a pop requested during the reset cycle
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        #1;
        chk("mid_count", 32'(count),      32'd0);
        chk("mid_empty", 32'(empty),      32'd1);
        chk("mid_addr0", 32'(ram_addr_0), 32'd0);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameters: DW, 8, data width; AW, 4, address width; DEPTH, 16, entries (2**AW).
REQ-002 SHALL have one clock and synchronous active-high reset: clk and rst, as listed below.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  producer has a byte to push.
REQ-006 in_data  input  DW  push data.
REQ-007 in_ready  output  1  push accepted this cycle if in_valid is also high; equals !full.
REQ-008 rd_en  input  1  pop request.
REQ-009 rd_data  output  DW  popped data; valid only while rd_valid is high.
REQ-010 rd_valid  output  1  one-cycle pulse marking rd_data valid.
REQ-011 full, empty  output  1 each  occupancy flags.
REQ-012 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 ovf_err, udf_err  output  1 each  sticky overflow and underflow flags.
REQ-014 ram_port_en_0, ram_wr_en  output  1 each  RAM write-port enables.
REQ-015 ram_addr_0  output  AW  RAM write address.
REQ-016 ram_data_in  output  DW  RAM write data.
REQ-017 ram_port_en_1  output  1  RAM read-port enable.
REQ-018 ram_addr_1  output  AW  RAM read address.
REQ-019 ram_data_out_1  input  DW  RAM read data, registered by the RAM one cycle after the port_en_1 edge.

Function
REQ-020 push_acc = in_valid & !full & !rst; pop_acc = rd_en & !empty & !rst, all combinational.
REQ-021 On push_acc, ram_port_en_0 and ram_wr_en SHALL be 1, ram_addr_0 SHALL equal wr_ptr and ram_data_in SHALL equal in_data in the same cycle; otherwise both enables SHALL be 0.
REQ-022 On pop_acc, ram_port_en_1 SHALL be 1 and ram_addr_1 SHALL equal rd_ptr; otherwise ram_port_en_1 SHALL be 0.
REQ-023 rd_valid SHALL be a register set to pop_acc, so it goes high exactly one cycle after an accepted pop; rd_data SHALL equal ram_data_out_1.
REQ-024 wr_ptr SHALL increment on push_acc and rd_ptr on pop_acc, each AW bits wide, wrapping from DEPTH-1 to 0.
REQ-025 count SHALL update as: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-026 full = (count==DEPTH) and empty = (count==0).
REQ-027 In a simultaneous push and pop while empty, only the push SHALL be accepted; while full, only the pop SHALL be accepted.
REQ-028 ovf_err SHALL set on in_valid & full, and udf_err SHALL set on rd_en & empty; both SHALL clear only on rst.
REQ-029 Refused requests SHALL change no pointer, no count and no RAM enable.
REQ-030 Order SHALL be strict FIFO; data written at an edge is readable by a pop issued in the following cycle.

Reset
REQ-031 While rst=1 at a clk edge, the following SHALL clear to 0: wr_ptr, rd_ptr, count, rd_valid, ovf_err, udf_err.
REQ-032 During reset, empty SHALL be 1 and full SHALL be 0.
REQ-033 While rst=1, all RAM enables SHALL be 0 combinationally.
REQ-034 Reset asserted mid-operation SHALL discard contents, and any rd_valid pending from a pop in the reset cycle SHALL NOT appear.

Verification
REQ-035 Reset scenario: rst for 2 cycles -> count=0, empty=1, full=0, in_ready=1, rd_valid=0, errors=0, no RAM enable.
REQ-036 Fill scenario: push 1..16 on consecutive cycles -> ram_addr_0 steps 0..15; full=1 and count=16 after the 16th push; a 17th push is refused and sets ovf_err=1 with no write.
REQ-037 Drain scenario: 16 consecutive pops -> rd_valid pulses one cycle after each pop with rd_data 1..16 in order; empty=1 at the end; a further pop sets udf_err=1 with ram_port_en_1=0.
REQ-038 Wrap scenario: push 10, pop 10, push 10 (values 0x20..0x29) -> ram_addr_0 wraps 15->0; pops return 0x20..0x29 in order.
REQ-039 Simultaneous scenario: at count=5, assert push and pop together for 4 cycles -> count stays 5 and popped data remains in order.
REQ-040 Reset mid-fill scenario: rst after 7 pushes -> count=0, empty=1; the next push writes ram_addr_0=0.
